// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station: default sizes and the
// internal opcode map used between decoder, station and ALU (0 = no-op).
package reservation_station_pkg;

    localparam int RS_SIZE_DEF = 16;
    localparam int ROB_W_DEF   = 6;
    localparam int OPCODE_W    = 6;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_NONE  = 6'd0;
    localparam opcode_t OP_LUI   = 6'd1;
    localparam opcode_t OP_AUIPC = 6'd2;
    localparam opcode_t OP_JAL   = 6'd3;
    localparam opcode_t OP_JALR  = 6'd4;
    localparam opcode_t OP_BEQ   = 6'd5;
    localparam opcode_t OP_BNE   = 6'd6;
    localparam opcode_t OP_BLT   = 6'd7;
    localparam opcode_t OP_BGE   = 6'd8;
    localparam opcode_t OP_BLTU  = 6'd9;
    localparam opcode_t OP_BGEU  = 6'd10;
    localparam opcode_t OP_ADDI  = 6'd11;
    localparam opcode_t OP_SLTI  = 6'd12;
    localparam opcode_t OP_SLTIU = 6'd13;
    localparam opcode_t OP_XORI  = 6'd14;
    localparam opcode_t OP_ORI   = 6'd15;
    localparam opcode_t OP_ANDI  = 6'd16;
    localparam opcode_t OP_SLLI  = 6'd17;
    localparam opcode_t OP_SRLI  = 6'd18;
    localparam opcode_t OP_SRAI  = 6'd19;
    localparam opcode_t OP_ADD   = 6'd20;
    localparam opcode_t OP_SUB   = 6'd21;
    localparam opcode_t OP_SLL   = 6'd22;
    localparam opcode_t OP_SLT   = 6'd23;
    localparam opcode_t OP_SLTU  = 6'd24;
    localparam opcode_t OP_XOR   = 6'd25;
    localparam opcode_t OP_SRL   = 6'd26;
    localparam opcode_t OP_SRA   = 6'd27;
    localparam opcode_t OP_OR    = 6'd28;
    localparam opcode_t OP_AND   = 6'd29;
    localparam opcode_t OP_LAST  = OP_AND;

endpackage

// File: rtl/rs_priority_select.sv
// Lowest-set-bit encoder: reports whether any request bit is set and the
// index of the lowest one. Used for free-slot and ready-entry selection.
module rs_priority_select #(
    parameter int N  = 16,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic          o_found,
    output logic [IW-1:0] o_index
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_found = |i_req;
        o_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order issue buffer feeding the ALU. Entries capture operands from
// the ALU and load CDBs; one operand-complete entry is dispatched per cycle.
//
// Handshake: the issuer may present issue_valid only while rs_full is low;
// an issue seen while full is dropped. The ALU side has no back-pressure:
// alu_opcode != 0 marks a valid dispatch for exactly that cycle.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int ROB_W   = ROB_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [5:0]       issue_opcode,
    input  logic             issue_qj_busy,
    input  logic             issue_qk_busy,
    input  logic [ROB_W-1:0] issue_qj,
    input  logic [ROB_W-1:0] issue_qk,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_pc,
    input  logic [ROB_W-1:0] issue_rob_index,
    output logic             rs_full,
    input  logic             alu_cdb_valid,
    input  logic [ROB_W-1:0] alu_cdb_rob_index,
    input  logic [31:0]      alu_cdb_res,
    input  logic             lsb_cdb_valid,
    input  logic [ROB_W-1:0] lsb_cdb_rob_index,
    input  logic [31:0]      lsb_cdb_res,
    output logic [5:0]       alu_opcode,
    output logic [31:0]      alu_val1,
    output logic [31:0]      alu_val2,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc,
    output logic [ROB_W-1:0] alu_rob_index
);

    localparam int IW = $clog2(RS_SIZE);

    // Entry storage, one array per field.
    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_qj_busy;
    logic [RS_SIZE-1:0] r_qk_busy;
    logic [5:0]         r_opcode [RS_SIZE];
    logic [ROB_W-1:0]   r_qj     [RS_SIZE];
    logic [ROB_W-1:0]   r_qk     [RS_SIZE];
    logic [31:0]        r_vj     [RS_SIZE];
    logic [31:0]        r_vk     [RS_SIZE];
    logic [31:0]        r_imm    [RS_SIZE];
    logic [31:0]        r_pc     [RS_SIZE];
    logic [ROB_W-1:0]   r_rob    [RS_SIZE];

    // Dispatch registers.
    logic [5:0]         r_alu_opcode;
    logic [31:0]        r_alu_val1;
    logic [31:0]        r_alu_val2;
    logic [31:0]        r_alu_imm;
    logic [31:0]        r_alu_pc;
    logic [ROB_W-1:0]   r_alu_rob;

    logic [RS_SIZE-1:0] w_free;
    logic [RS_SIZE-1:0] w_ready;
    logic               w_free_found;
    logic [IW-1:0]      w_free_idx;
    logic               w_rdy_found;
    logic [IW-1:0]      w_rdy_idx;
    logic               w_issue_en;

    logic [RS_SIZE-1:0] w_j_wake;
    logic [RS_SIZE-1:0] w_k_wake;
    logic [31:0]        w_j_val [RS_SIZE];
    logic [31:0]        w_k_val [RS_SIZE];

    logic               w_iss_qj_busy;
    logic               w_iss_qk_busy;
    logic [31:0]        w_iss_vj;
    logic [31:0]        w_iss_vk;

    assign w_free     = ~r_busy;
    assign w_ready    = r_busy & ~r_qj_busy & ~r_qk_busy;
    assign rs_full    = &r_busy;
    assign w_issue_en = issue_valid & w_free_found;

    rs_priority_select #(.N(RS_SIZE), .IW(IW)) u_free_sel (
        .i_req   (w_free),
        .o_found (w_free_found),
        .o_index (w_free_idx)
    );

    rs_priority_select #(.N(RS_SIZE), .IW(IW)) u_ready_sel (
        .i_req   (w_ready),
        .o_found (w_rdy_found),
        .o_index (w_rdy_idx)
    );

    // Per-entry CDB tag match; the ALU bus wins if both buses match.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_j_wake[i] = 1'b0;
            w_k_wake[i] = 1'b0;
            w_j_val[i]  = '0;
            w_k_val[i]  = '0;
            if (alu_cdb_valid && r_qj[i] == alu_cdb_rob_index) begin
                w_j_wake[i] = 1'b1;
                w_j_val[i]  = alu_cdb_res;
            end else if (lsb_cdb_valid && r_qj[i] == lsb_cdb_rob_index) begin
                w_j_wake[i] = 1'b1;
                w_j_val[i]  = lsb_cdb_res;
            end
            if (alu_cdb_valid && r_qk[i] == alu_cdb_rob_index) begin
                w_k_wake[i] = 1'b1;
                w_k_val[i]  = alu_cdb_res;
            end else if (lsb_cdb_valid && r_qk[i] == lsb_cdb_rob_index) begin
                w_k_wake[i] = 1'b1;
                w_k_val[i]  = lsb_cdb_res;
            end
        end
    end

    // Issue-time forwarding from a same-cycle CDB broadcast.
    always_comb begin
        w_iss_qj_busy = issue_qj_busy;
        w_iss_qk_busy = issue_qk_busy;
        w_iss_vj      = issue_vj;
        w_iss_vk      = issue_vk;
        if (issue_qj_busy) begin
            if (alu_cdb_valid && issue_qj == alu_cdb_rob_index) begin
                w_iss_qj_busy = 1'b0;
                w_iss_vj      = alu_cdb_res;
            end else if (lsb_cdb_valid && issue_qj == lsb_cdb_rob_index) begin
                w_iss_qj_busy = 1'b0;
                w_iss_vj      = lsb_cdb_res;
            end
        end
        if (issue_qk_busy) begin
            if (alu_cdb_valid && issue_qk == alu_cdb_rob_index) begin
                w_iss_qk_busy = 1'b0;
                w_iss_vk      = alu_cdb_res;
            end else if (lsb_cdb_valid && issue_qk == lsb_cdb_rob_index) begin
                w_iss_qk_busy = 1'b0;
                w_iss_vk      = lsb_cdb_res;
            end
        end
    end

    // Control state: busy/pending bits and the dispatch registers. The issue
    // slot is chosen from pre-edge busy bits, so a slot freed by this edge's
    // dispatch is never the one written by this edge's issue.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy       <= '0;
            r_qj_busy    <= '0;
            r_qk_busy    <= '0;
            r_alu_opcode <= '0;
            r_alu_val1   <= '0;
            r_alu_val2   <= '0;
            r_alu_imm    <= '0;
            r_alu_pc     <= '0;
            r_alu_rob    <= '0;
        end else if (flush) begin
            r_busy       <= '0;
            r_alu_opcode <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_qj_busy[i] && w_j_wake[i]) begin
                    r_qj_busy[i] <= 1'b0;
                end
                if (r_busy[i] && r_qk_busy[i] && w_k_wake[i]) begin
                    r_qk_busy[i] <= 1'b0;
                end
            end
            if (w_rdy_found) begin
                r_alu_opcode      <= r_opcode[w_rdy_idx];
                r_alu_val1        <= r_vj[w_rdy_idx];
                r_alu_val2        <= r_vk[w_rdy_idx];
                r_alu_imm         <= r_imm[w_rdy_idx];
                r_alu_pc          <= r_pc[w_rdy_idx];
                r_alu_rob         <= r_rob[w_rdy_idx];
                r_busy[w_rdy_idx] <= 1'b0;
            end else begin
                r_alu_opcode <= '0;
            end
            if (w_issue_en) begin
                r_busy[w_free_idx]    <= 1'b1;
                r_qj_busy[w_free_idx] <= w_iss_qj_busy;
                r_qk_busy[w_free_idx] <= w_iss_qk_busy;
            end
        end
    end

    // Payload fields: captured on issue and on wakeup; qualified by busy.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (r_busy[i] && r_qj_busy[i] && w_j_wake[i]) begin
                r_vj[i] <= w_j_val[i];
            end
            if (r_busy[i] && r_qk_busy[i] && w_k_wake[i]) begin
                r_vk[i] <= w_k_val[i];
            end
        end
        if (w_issue_en) begin
            r_opcode[w_free_idx] <= issue_opcode;
            r_qj[w_free_idx]     <= issue_qj;
            r_qk[w_free_idx]     <= issue_qk;
            r_vj[w_free_idx]     <= w_iss_vj;
            r_vk[w_free_idx]     <= w_iss_vk;
            r_imm[w_free_idx]    <= issue_imm;
            r_pc[w_free_idx]     <= issue_pc;
            r_rob[w_free_idx]    <= issue_rob_index;
        end
    end

    assign alu_opcode    = r_alu_opcode;
    assign alu_val1      = r_alu_val1;
    assign alu_val2      = r_alu_val2;
    assign alu_imm       = r_alu_imm;
    assign alu_pc        = r_alu_pc;
    assign alu_rob_index = r_alu_rob;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios followed
// by randomized traffic, all checked against a behavioural entry model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int RS    = 16;
  localparam int RW    = 6;
  localparam int OUT_W = 6 + 32 * 4 + RW;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  // ---------------- DUT signals ----------------
  logic          flush;
  logic          issue_valid;
  logic [5:0]    issue_opcode;
  logic          issue_qj_busy, issue_qk_busy;
  logic [RW-1:0] issue_qj, issue_qk;
  logic [31:0]   issue_vj, issue_vk, issue_imm, issue_pc;
  logic [RW-1:0] issue_rob_index;
  logic          rs_full;
  logic          alu_cdb_valid;
  logic [RW-1:0] alu_cdb_rob_index;
  logic [31:0]   alu_cdb_res;
  logic          lsb_cdb_valid;
  logic [RW-1:0] lsb_cdb_rob_index;
  logic [31:0]   lsb_cdb_res;
  logic [5:0]    alu_opcode;
  logic [31:0]   alu_val1, alu_val2, alu_imm, alu_pc;
  logic [RW-1:0] alu_rob_index;

  reservation_station #(.RS_SIZE(RS), .ROB_W(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush(flush),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_rob_index(issue_rob_index), .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_index(alu_cdb_rob_index),
    .alu_cdb_res(alu_cdb_res),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_index(lsb_cdb_rob_index),
    .lsb_cdb_res(lsb_cdb_res),
    .alu_opcode(alu_opcode), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_index(alu_rob_index)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit            busy;
    logic [5:0]    op;
    bit            jb;
    logic [RW-1:0] qj;
    logic [31:0]   vj;
    bit            kb;
    logic [RW-1:0] qk;
    logic [31:0]   vk;
    logic [31:0]   imm;
    logic [31:0]   pc;
    logic [RW-1:0] rob;
  } ent_t;

  ent_t          m_ent [RS];
  logic [5:0]    m_op;
  logic [31:0]   m_v1, m_v2, m_imm, m_pc;
  logic [RW-1:0] m_rob;

  logic [OUT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RS; i++) m_ent[i].busy = 0;
    m_op = '0; m_v1 = '0; m_v2 = '0; m_imm = '0; m_pc = '0; m_rob = '0;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < RS; i++) if (m_ent[i].busy) c++;
    return c;
  endfunction

  // Resolve one operand against the two broadcast buses (ALU wins).
  task automatic snoop(inout bit b, input logic [RW-1:0] q, inout logic [31:0] v);
    if (b) begin
      if (alu_cdb_valid && q == alu_cdb_rob_index) begin b = 0; v = alu_cdb_res; end
      else if (lsb_cdb_valid && q == lsb_cdb_rob_index) begin b = 0; v = lsb_cdb_res; end
    end
  endtask

  // Apply the current input values as one clock edge to the model.
  task automatic model_edge();
    int   d = -1;
    int   f = -1;
    ent_t n;
    if (flush) begin
      for (int i = 0; i < RS; i++) m_ent[i].busy = 0;
      m_op = '0;
      return;
    end
    for (int i = RS - 1; i >= 0; i--) begin
      if (m_ent[i].busy && !m_ent[i].jb && !m_ent[i].kb) d = i;
      if (!m_ent[i].busy) f = i;
    end
    if (d >= 0) begin
      m_op = m_ent[d].op; m_v1 = m_ent[d].vj; m_v2 = m_ent[d].vk;
      m_imm = m_ent[d].imm; m_pc = m_ent[d].pc; m_rob = m_ent[d].rob;
      m_ent[d].busy = 0;
    end else begin
      m_op = '0;
    end
    for (int i = 0; i < RS; i++) begin
      if (m_ent[i].busy) begin
        snoop(m_ent[i].jb, m_ent[i].qj, m_ent[i].vj);
        snoop(m_ent[i].kb, m_ent[i].qk, m_ent[i].vk);
      end
    end
    if (issue_valid && f >= 0) begin
      n.busy = 1; n.op = issue_opcode;
      n.jb = issue_qj_busy; n.qj = issue_qj; n.vj = issue_vj;
      n.kb = issue_qk_busy; n.qk = issue_qk; n.vk = issue_vk;
      n.imm = issue_imm; n.pc = issue_pc; n.rob = issue_rob_index;
      snoop(n.jb, n.qj, n.vj);
      snoop(n.kb, n.qk, n.vk);
      m_ent[f] = n;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    flush = 0; issue_valid = 0; issue_opcode = '0;
    issue_qj_busy = 0; issue_qk_busy = 0; issue_qj = '0; issue_qk = '0;
    issue_vj = '0; issue_vk = '0; issue_imm = '0; issue_pc = '0;
    issue_rob_index = '0;
    alu_cdb_valid = 0; alu_cdb_rob_index = '0; alu_cdb_res = '0;
    lsb_cdb_valid = 0; lsb_cdb_rob_index = '0; lsb_cdb_res = '0;
  endtask

  task automatic drive_issue(input logic [5:0] op, input bit jb, input logic [RW-1:0] qj,
                             input logic [31:0] vj, input bit kb, input logic [RW-1:0] qk,
                             input logic [31:0] vk, input logic [31:0] imm,
                             input logic [31:0] pc, input logic [RW-1:0] rob);
    issue_valid = 1; issue_opcode = op;
    issue_qj_busy = jb; issue_qj = qj; issue_vj = vj;
    issue_qk_busy = kb; issue_qk = qk; issue_vk = vk;
    issue_imm = imm; issue_pc = pc; issue_rob_index = rob;
  endtask

  // One clock: model the edge, queue the expectation, compare after the edge.
  task automatic step();
    logic [OUT_W-1:0] e;
    model_edge();
    exp_q.push_back({m_op, m_v1, m_v2, m_imm, m_pc, m_rob});
    @(posedge clk_in);
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_underflow", 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check("alu_opcode", 64'(alu_opcode),    64'(e[OUT_W-1 -: 6]));
      check("alu_val1",   64'(alu_val1),      64'(e[133:102]));
      check("alu_val2",   64'(alu_val2),      64'(e[101:70]));
      check("alu_imm",    64'(alu_imm),       64'(e[69:38]));
      check("alu_pc",     64'(alu_pc),        64'(e[37:6]));
      check("alu_rob",    64'(alu_rob_index), 64'(e[RW-1:0]));
    end
    check("rs_full", 64'(rs_full), 64'(model_count() == RS));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      step();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive_idle();
    model_reset();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_opcode", 64'(alu_opcode), 64'(0));
    check("reset_val1",   64'(alu_val1),   64'(0));
    check("reset_rob",    64'(alu_rob_index), 64'(0));
    check("reset_full",   64'(rs_full),    64'(0));
    @(negedge clk_in);
    rst_in = 1'b0;

    // Basic dispatch: ready at issue, dispatched one edge later.
    drive_idle();
    drive_issue(OP_ADD, 0, '0, 32'd5, 0, '0, 32'd7, 32'd0, 32'h40, 6'd3);
    step();
    check("basic_e0_op", 64'(alu_opcode), 64'(0));
    idle_steps(1);
    check("basic_op",   64'(alu_opcode),    64'(OP_ADD));
    check("basic_val1", 64'(alu_val1),      64'(5));
    check("basic_val2", 64'(alu_val2),      64'(7));
    check("basic_rob",  64'(alu_rob_index), 64'(3));
    idle_steps(1);
    check("basic_after", 64'(alu_opcode), 64'(0));

    // Wakeup from the load CDB.
    drive_idle();
    drive_issue(OP_SUB, 1, 6'd9, 32'd0, 0, '0, 32'd1, 32'd0, 32'h44, 6'd10);
    step();
    idle_steps(2);
    drive_idle();
    lsb_cdb_valid = 1; lsb_cdb_rob_index = 6'd9; lsb_cdb_res = 32'h10;
    step();
    check("wake_capture_op", 64'(alu_opcode), 64'(0));
    idle_steps(1);
    check("wake_op",   64'(alu_opcode), 64'(OP_SUB));
    check("wake_val1", 64'(alu_val1),   64'(32'h10));
    check("wake_val2", 64'(alu_val2),   64'(1));

    // Forwarding at issue from the ALU CDB.
    drive_idle();
    drive_issue(OP_ADDI, 1, 6'd4, 32'd0, 0, '0, 32'd0, 32'd12, 32'h48, 6'd11);
    alu_cdb_valid = 1; alu_cdb_rob_index = 6'd4; alu_cdb_res = 32'hFFFF_FFFF;
    step();
    idle_steps(1);
    check("fwd_op",   64'(alu_opcode), 64'(OP_ADDI));
    check("fwd_val1", 64'(alu_val1),   64'(32'hFFFF_FFFF));
    idle_steps(1);

    // Fill, overflow, then drain in index order.
    for (int i = 0; i < RS; i++) begin
      drive_idle();
      drive_issue(OP_ADD, 1, 6'd1, 32'd0, 0, '0, 32'(i), 32'(i), 32'(i * 4), 6'(i + 16));
      step();
    end
    check("fill_full", 64'(rs_full), 64'(1));
    drive_idle();
    drive_issue(OP_OR, 0, '0, 32'd1, 0, '0, 32'd2, 32'd0, 32'd0, 6'd50);
    step();
    drive_idle();
    alu_cdb_valid = 1; alu_cdb_rob_index = 6'd1; alu_cdb_res = 32'hCAFE;
    step();
    for (int i = 0; i < RS; i++) begin
      idle_steps(1);
      check("drain_rob", 64'(alu_rob_index), 64'(i + 16));
    end
    check("drain_full", 64'(rs_full), 64'(0));
    idle_steps(1);
    check("drain_done", 64'(alu_opcode), 64'(0));

    // Flush with a simultaneous issue.
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      drive_issue(OP_AND, 1, 6'd2, 32'd0, 0, '0, 32'd3, 32'd0, 32'd0, 6'(i + 20));
      step();
    end
    drive_idle();
    flush = 1;
    drive_issue(OP_XOR, 0, '0, 32'd1, 0, '0, 32'd1, 32'd0, 32'd0, 6'd60);
    step();
    check("flush_op",   64'(alu_opcode), 64'(0));
    check("flush_full", 64'(rs_full),    64'(0));
    drive_idle();
    alu_cdb_valid = 1; alu_cdb_rob_index = 6'd2; alu_cdb_res = 32'h77;
    step();
    idle_steps(2);
    check("flush_quiet", 64'(alu_opcode), 64'(0));

    // Asynchronous reset mid-cycle with entries busy and outputs loaded.
    drive_idle();
    drive_issue(OP_SLT, 1, 6'd3, 32'd0, 0, '0, 32'd0, 32'd0, 32'd0, 6'd30);
    step();
    drive_idle();
    drive_issue(OP_XOR, 0, '0, 32'hAA, 0, '0, 32'h55, 32'h1234, 32'h100, 6'd7);
    step();
    idle_steps(1);
    check("pre_rst_op", 64'(alu_opcode), 64'(OP_XOR));
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_op",   64'(alu_opcode),    64'(0));
    check("arst_val1", 64'(alu_val1),      64'(0));
    check("arst_val2", 64'(alu_val2),      64'(0));
    check("arst_imm",  64'(alu_imm),       64'(0));
    check("arst_pc",   64'(alu_pc),        64'(0));
    check("arst_rob",  64'(alu_rob_index), 64'(0));
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      drive_idle();
      if (model_count() < RS && $urandom_range(0, 99) < 60) begin
        drive_issue(6'($urandom_range(1, int'(OP_LAST))),
                    bit'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                    bit'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                    $urandom, $urandom, 6'($urandom_range(0, 63)));
      end
      if ($urandom_range(0, 99) < 40) begin
        alu_cdb_valid = 1; alu_cdb_rob_index = 6'($urandom_range(0, 7)); alu_cdb_res = $urandom;
      end
      if ($urandom_range(0, 99) < 40) begin
        lsb_cdb_valid = 1; lsb_cdb_rob_index = 6'($urandom_range(0, 7)); lsb_cdb_res = $urandom;
        if (alu_cdb_valid && lsb_cdb_rob_index == alu_cdb_rob_index) lsb_cdb_valid = 0;
      end
      if ($urandom_range(0, 99) < 2) flush = 1;
      step();
    end
    idle_steps(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

- Out-of-order issue buffer between the decoder/issue stage and the arithmetic logic unit.
- Holds up to `RS_SIZE` non-memory-address-pending instructions and captures operand values from CDB broadcasts (ALU results and LSB load results).
- Each cycle it sends at most one operand-complete entry to the ALU, on registered outputs; `opcode == 0` means no instruction that cycle.
- It is the producer side of the ALU's `opcode/val1/val2/imm/pc/rob_index` interface.

## Interface
Parameters:
- `RS_SIZE`, 16, number of entries (power of two, ≥2)
- `ROB_W`, 6, ROB tag width

Ports:
- `clk_in` in 1: the block's single clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `flush` in 1: mispredict flush; clears all entries.
- `issue_valid` in 1: new instruction present this cycle.
- `issue_opcode` in 6: internal opcode from `config.vh` (never 0 when valid).
- `issue_qj_busy`, `issue_qk_busy` in 1: operand still pending in ROB.
- `issue_qj`, `issue_qk` in ROB_W: producing ROB tag when busy.
- `issue_vj`, `issue_vk` in 32: operand value when not busy.
- `issue_imm`, `issue_pc` in 32: immediate and PC.
- `issue_rob_index` in ROB_W: destination ROB tag.
- `rs_full` out 1: no free entry (combinational from entry-valid vector).
- `alu_cdb_valid` in 1, `alu_cdb_rob_index` in ROB_W, `alu_cdb_res` in 32: ALU broadcast.
- `lsb_cdb_valid` in 1, `lsb_cdb_rob_index` in ROB_W, `lsb_cdb_res` in 32: load broadcast.
- `alu_opcode` out 6, `alu_val1` out 32, `alu_val2` out 32, `alu_imm` out 32, `alu_pc` out 32, `alu_rob_index` out ROB_W: registered dispatch to the ALU.

## Operation
- Entry fields:
  - `busy`, `opcode`
  - `qj_busy`, `qj`, `vj`
  - `qk_busy`, `qk`, `vk`
  - `imm`, `pc`, `rob_index`
- An entry is ready when `busy & ~qj_busy & ~qk_busy`.

Allocation:
- Issue writes the lowest-index free entry.
- If `issue_valid` arrives while `rs_full` is asserted, the issue is ignored; issuer protocol forbids this.

Issue-time forwarding:
- If `issue_qj_busy` and a valid CDB in the same cycle carries a matching tag, store `vj = cdb_res` and `qj_busy = 0`. Same rule for k.
- ALU CDB takes precedence if both CDBs match; this cannot occur legally.

Wakeup:
- Every busy entry with a pending operand compares its tag against both CDBs each cycle.
- On a match it captures the value and clears the busy bit.
- j and k update independently; both may wake in one cycle.

Dispatch:
- Each edge, select the lowest-index ready entry, using register state *before* this edge's wakeups.
- Load the ALU output registers from it and free the entry.
- If no entry is ready, drive `alu_opcode = 0`; other ALU outputs hold.

Simultaneous events:
- Issue and dispatch in the same cycle are legal, including when exactly one entry is free.
- The freed slot is not reused until the next edge.

Flush:
- At the edge, flush clears all `busy` bits and sets `alu_opcode = 0`.
- Flush has priority over issue, wakeup and dispatch.

## Timing
- Reset state:
  - all `busy = 0`, so `rs_full = 0`
  - `alu_opcode = 0`
  - `alu_val1`, `alu_val2`, `alu_imm`, `alu_pc` = 0
  - `alu_rob_index` = 0
- Latency, operands ready at issue: issue sampled at edge E0; earliest dispatch edge E1; ALU result valid during the cycle after E1.
- Latency, woken by CDB: value captured at edge Ew; earliest dispatch edge Ew+1.
- Forwarded at issue: the same latency as operands ready at issue.
- Throughput: one dispatch per cycle.
- Ordering: none, beyond the lowest-index tie-break.
- `rs_full` drops in the cycle after a dispatch edge frees an entry.

## Structure
- `config.vh` holds:
  - opcode defines (`LUI` … `AND`, 0 = none)
  - `RS_SIZE`
  - ROB tag width
- Sub-module `rs_priority_select`: parameterised lowest-set-bit encoder, used twice (free-slot search and ready-entry search). It outputs `found` and `index`.
- Entry storage is per-field arrays in the top module.

## Test plan
- Basic dispatch: reset, then issue ADD with `vj=5`, `vk=7`, rob 3, both not busy → next edge `alu_opcode=ADD`, `val1=5`, `val2=7`, `alu_rob_index=3`; following edge `alu_opcode=0`.
- Wakeup: issue SUB with `qj_busy`, `qj=9`, `vk=1`; two cycles later pulse `lsb_cdb` with rob 9, res 0x10 → dispatch exactly one edge after the capture, with `val1=0x10`, `val2=1`.
- Forwarding at issue: issue ADDI with `qj_busy`, `qj=4` in the same cycle `alu_cdb` broadcasts rob 4, res 0xFFFF_FFFF → dispatch next edge with `val1=0xFFFF_FFFF`.
- Fill and overflow: issue 16 entries all waiting on tag 1 → `rs_full=1`; an extra issue is ignored. Broadcast tag 1 → 16 consecutive dispatches in index order, then `opcode=0` and `rs_full=0`.
- Flush: with 5 busy entries, assert `flush` together with `issue_valid` → all entries cleared, the new issue dropped, `alu_opcode=0`; no dispatches until new issues.
- Asynchronous reset: assert `rst_in` mid-cycle with entries busy → outputs are the reset values immediately, without waiting for a clock edge.
